// File: rtl/led_pattern_pkg.sv
// Shared constants for the Choreo8 LED pattern engine: pattern codes, LFSR
// taps/seeds per supported width, marquee seed and the centred-fill frame helper.
package led_pattern_pkg;

    localparam logic [2:0] PAT_KNIGHT  = 3'd0;
    localparam logic [2:0] PAT_WALK    = 3'd1;
    localparam logic [2:0] PAT_EXPAND  = 3'd2;
    localparam logic [2:0] PAT_BLINK   = 3'd3;
    localparam logic [2:0] PAT_ALT     = 3'd4;
    localparam logic [2:0] PAT_MARQUEE = 3'd5;
    localparam logic [2:0] PAT_SPARKLE = 3'd6;
    localparam logic [2:0] PAT_OFF     = 3'd7;

    localparam logic [31:0] MARQUEE_SEED = 32'h0000_0007;

    // Maximal-length Fibonacci taps (mask of register bits xored into bit0)
    localparam logic [31:0] LFSR_TAPS_8  = 32'h0000_00B8;
    localparam logic [31:0] LFSR_TAPS_16 = 32'h0000_B400;
    localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED_8  = 32'h0000_00A5;
    localparam logic [31:0] LFSR_SEED_16 = 32'h0000_ACE1;
    localparam logic [31:0] LFSR_SEED_32 = 32'h1234_5678;

    function automatic logic [31:0] lfsr_taps(input int w);
        case (w)
            8:       return LFSR_TAPS_8;
            16:      return LFSR_TAPS_16;
            default: return LFSR_TAPS_32;
        endcase
    endfunction

    function automatic logic [31:0] lfsr_seed(input int w);
        case (w)
            8:       return LFSR_SEED_8;
            16:      return LFSR_SEED_16;
            default: return LFSR_SEED_32;
        endcase
    endfunction

    // e < w/2 grows 2(e+1) centred ones, then mirrors back down, last index is dark.
    // A shift by 32 yields 0, so the full-width case still produces all ones.
    function automatic logic [31:0] centre_fill(input int w, input int e);
        int h;
        int k;
        h = w / 2;
        if (e < h)          k = e;
        else if (e < w - 1) k = w - 2 - e;
        else                return 32'd0;
        return ((32'd1 << (2 * k + 2)) - 32'd1) << (h - 1 - k);
    endfunction

endpackage

// File: rtl/led_step_timer.sv
// Step prescaler for the LED pattern engine: clock-enable step_en every
// speed_div+1 running cycles, frozen while disabled or paused.
module led_step_timer
    import led_pattern_pkg::*;
#(
    parameter int PRESC_W = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               pause,
    input  logic [PRESC_W-1:0] speed_div,
    output logic               step_en
);

    logic [PRESC_W-1:0] cnt;
    logic               run;

    assign run = ena & ~pause;
    // >= so a speed_div lowered below the running count steps immediately
    assign step_en = run && (cnt >= speed_div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       cnt <= '0;
        else if (step_en) cnt <= '0;
        else if (run)     cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/led_pattern_engine.sv
// Choreo8 LED pattern engine: prescaled frame stepping with step-aligned pattern
// loads. Optional LED_PWM_EN adds a brightness port and 16-phase PWM on led_out.
module led_pattern_engine
    import led_pattern_pkg::*;
#(
    parameter int LED_W   = 8,
    parameter int PRESC_W = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               pause,
    input  logic [2:0]         pat_sel,
    input  logic               pat_load,
    input  logic [PRESC_W-1:0] speed_div,
`ifdef LED_PWM_EN
    input  logic [3:0]         brightness,
`endif
    output logic [LED_W-1:0]   led_out,
    output logic [2:0]         pat_active,
    output logic               step_pulse
);

    localparam int H     = LED_W / 2;
    localparam int IDX_W = $clog2(2 * LED_W);
    localparam logic [LED_W-1:0] TAPS   = LED_W'(lfsr_taps(LED_W));
    localparam logic [LED_W-1:0] SEED   = LED_W'(lfsr_seed(LED_W));
    localparam logic [LED_W-1:0] MQ     = LED_W'(MARQUEE_SEED);
    localparam logic [LED_W-1:0] ONE    = LED_W'(1);
    localparam logic [LED_W-1:0] TWO_ON = LED_W'(3);

    if (!(LED_W == 8 || LED_W == 16 || LED_W == 32)) begin : g_bad_width
        $error("led_pattern_engine: LED_W must be 8, 16 or 32");
    end

    function automatic logic [LED_W-1:0] frame_of(input logic [2:0] p,
                                                  input logic [IDX_W-1:0] i,
                                                  input logic [LED_W-1:0] s);
        int k;
        int b;
        k = int'(i);
        b = 0;
        frame_of = '0;
        case (p)
            PAT_KNIGHT: begin
                b = (k < H) ? k : 2 * H - 2 - k;
                frame_of = (ONE << b) | (ONE << (LED_W - 1 - b));
            end
            PAT_WALK: begin
                b = (k <= LED_W - 2) ? k : 2 * (LED_W - 2) - k;
                frame_of = TWO_ON << b;
            end
            PAT_EXPAND:  frame_of = LED_W'(centre_fill(LED_W, k));
            PAT_BLINK:   frame_of = (k == 0) ? '1 : '0;
            PAT_ALT:     frame_of = (k == 0) ? {H{2'b10}} : {H{2'b01}};
            PAT_MARQUEE: frame_of = (MQ << k) | (MQ >> (LED_W - k));
            PAT_SPARKLE: frame_of = (s == '0) ? SEED : s;
            default:     frame_of = '0;
        endcase
    endfunction

    // Index wraps at the end of each pattern's frame period
    function automatic logic [IDX_W-1:0] next_idx(input logic [2:0] p,
                                                  input logic [IDX_W-1:0] i);
        logic [IDX_W-1:0] last;
        case (p)
            PAT_KNIGHT:              last = IDX_W'(2 * H - 3);
            PAT_WALK:                last = IDX_W'(2 * LED_W - 5);
            PAT_EXPAND, PAT_MARQUEE: last = IDX_W'(LED_W - 1);
            PAT_BLINK, PAT_ALT:      last = IDX_W'(1);
            default:                 last = '0;
        endcase
        return (i >= last) ? '0 : i + 1'b1;
    endfunction

    function automatic logic [LED_W-1:0] lfsr_next(input logic [LED_W-1:0] s);
        logic [LED_W-1:0] v;
        v = (s == '0) ? SEED : s;
        return {v[LED_W-2:0], ^(v & TAPS)};
    endfunction

    logic             step_en;
    logic [LED_W-1:0] frame_q;
    logic [LED_W-1:0] lfsr_q;
    logic [LED_W-1:0] cur_lfsr;
    logic [2:0]       pat_q;
    logic [2:0]       pend_q;
    logic [2:0]       cur_pat;
    logic             pend_vld;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] cur_idx;

    led_step_timer #(.PRESC_W(PRESC_W)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .pause     (pause),
        .speed_div (speed_div),
        .step_en   (step_en)
    );

    // A pending load replaces the running pattern with its first-frame state
    always_comb begin
        cur_pat  = pat_q;
        cur_idx  = idx_q;
        cur_lfsr = lfsr_q;
        if (pend_vld) begin
            cur_pat  = pend_q;
            cur_idx  = '0;
            cur_lfsr = SEED;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q    <= '0;
            pat_q      <= PAT_KNIGHT;
            pend_q     <= PAT_KNIGHT;
            pend_vld   <= 1'b0;
            idx_q      <= '0;
            lfsr_q     <= SEED;
            step_pulse <= 1'b0;
        end else begin
            step_pulse <= step_en;
            if (step_en) begin
                frame_q  <= frame_of(cur_pat, cur_idx, cur_lfsr);
                pat_q    <= cur_pat;
                idx_q    <= next_idx(cur_pat, cur_idx);
                lfsr_q   <= lfsr_next(cur_lfsr);
                pend_vld <= 1'b0;
            end
            // Placed after the step so a coincident load survives to the next step
            if (pat_load && ena) begin
                pend_q   <= pat_sel;
                pend_vld <= 1'b1;
            end
        end
    end

    assign pat_active = pat_q;

`ifdef LED_PWM_EN
    logic [3:0] pwm_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_cnt <= 4'd0;
        else        pwm_cnt <= pwm_cnt + 4'd1;
    end

    assign led_out = frame_q & {LED_W{pwm_cnt < brightness}};
`else
    assign led_out = frame_q;
`endif

endmodule

// File: tb/tb_led_pattern_engine.sv
// Self-checking bench for led_pattern_engine (LED_W=8): directed sequence plus
// randomized pattern/speed/pause runs checked against a frame-rule model.
module tb_led_pattern_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        pause;
    logic        pat_load;
    logic        step_pulse;
    logic [2:0]  pat_sel;
    logic [2:0]  pat_active;
    logic [23:0] speed_div;
    logic [7:0]  led_out;
`ifdef LED_PWM_EN
    logic [3:0]  brightness;
    logic [3:0]  pwm_m;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_pattern_engine #(.LED_W(8), .PRESC_W(24)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .pause      (pause),
        .pat_sel    (pat_sel),
        .pat_load   (pat_load),
        .speed_div  (speed_div),
`ifdef LED_PWM_EN
        .brightness (brightness),
`endif
        .led_out    (led_out),
        .pat_active (pat_active),
        .step_pulse (step_pulse)
    );

`ifdef LED_PWM_EN
    always @(posedge clk or negedge rst_n)
        if (!rst_n) pwm_m <= 4'd0;
        else        pwm_m <= pwm_m + 4'd1;
`endif

    // Expected frame k steps after a pattern starts, from the frame rules
    function automatic logic [7:0] exp_frame(input int pat, input int k);
        int p;
        int s;
        int fb;
        case (pat)
            0: begin
                p = k % 6;
                if (p > 3) p = 6 - p;
                return 8'((1 << p) | (1 << (7 - p)));
            end
            1: begin
                p = k % 12;
                if (p > 6) p = 12 - p;
                return 8'(3 << p);
            end
            2: case (k % 8)
                   0: return 8'h18;
                   1: return 8'h3C;
                   2: return 8'h7E;
                   3: return 8'hFF;
                   4: return 8'h7E;
                   5: return 8'h3C;
                   6: return 8'h18;
                   default: return 8'h00;
               endcase
            3: return (k % 2 == 0) ? 8'hFF : 8'h00;
            4: return (k % 2 == 0) ? 8'hAA : 8'h55;
            5: begin
                p = k % 8;
                return 8'(((7 << p) | (7 >> (8 - p))) & 255);
            end
            6: begin
                s = 'hA5;
                for (int j = 0; j < k; j++) begin
                    fb = ((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1;
                    s  = ((s << 1) | fb) & 255;
                end
                return 8'(s);
            end
            default: return 8'h00;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_led(input string tag, input logic [7:0] f);
`ifdef LED_PWM_EN
        chk(tag, {24'd0, led_out}, (pwm_m < brightness) ? {24'd0, f} : 32'd0);
`else
        chk(tag, {24'd0, led_out}, {24'd0, f});
`endif
    endtask

    task automatic wait_step(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!step_pulse && n < 200);
        chk("step_seen", {31'd0, step_pulse}, 32'd1);
    endtask

    task automatic load(input int p);
        pat_sel  = 3'(p);
        pat_load = 1'b1;
        @(negedge clk);
        pat_load = 1'b0;
    endtask

    task automatic run_steps(input int pat, input int k0, input int n, input int iv);
        int c;
        for (int j = 0; j < n; j++) begin
            wait_step(c);
            if (iv >= 0) chk("interval", c, iv);
            chk_led("frame", exp_frame(pat, k0 + j));
            chk("pat_active", {29'd0, pat_active}, pat);
        end
    endtask

    initial begin
        int c;
        int dups;
        logic [255:0] seen;
        rst_n = 1'b0; ena = 1'b0; pause = 1'b0; pat_load = 1'b0;
        pat_sel = 3'd0; speed_div = 24'd3;
`ifdef LED_PWM_EN
        brightness = 4'd15;
`endif
        #2;
        chk("rst_led", {24'd0, led_out}, 32'd0);
        chk("rst_pat", {29'd0, pat_active}, 32'd0);
        chk("rst_pulse", {31'd0, step_pulse}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ena   = 1'b1;

        // Knight from reset: first step after speed_div+1 run cycles
        wait_step(c);
        chk("first_step", c, 4);
        chk_led("knight0", 8'h81);
        @(negedge clk);
        chk("pulse_width", {31'd0, step_pulse}, 32'd0);
        run_steps(0, 1, 1, -1);
        run_steps(0, 2, 5, 4);

        // Load expand mid-knight
        load(2);
        chk("pat_before_step", {29'd0, pat_active}, 32'd0);
        run_steps(2, 0, 1, -1);
        run_steps(2, 1, 8, 4);

        // Pause marquee at 0x0E with cnt held at 1
        load(5);
        run_steps(5, 0, 1, -1);
        run_steps(5, 1, 1, 4);
        @(negedge clk);
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_led("pause_hold", 8'h0E);
            chk("pause_pulse", {31'd0, step_pulse}, 32'd0);
        end
        pause = 1'b0;
        wait_step(c);
        chk("resume_iv", c, 3);
        chk_led("resume_frame", 8'h1C);

        // Load coinciding with a step applies one step later
        repeat (3) @(negedge clk);
        load(3);
        chk("coinc_pulse", {31'd0, step_pulse}, 32'd1);
        chk_led("coinc_frame", 8'h38);
        chk("coinc_pat", {29'd0, pat_active}, 32'd5);
        run_steps(3, 0, 2, 4);

        // ena low ignores pat_load and freezes everything
        @(negedge clk);
        ena = 1'b0;
        load(7);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("dis_pulse", {31'd0, step_pulse}, 32'd0);
            chk_led("dis_hold", 8'h00);
        end
        ena = 1'b1;
        wait_step(c);
        chk("ena_resume_iv", c, 3);
        chk_led("ena_frame", 8'hFF);
        chk("ena_pat", {29'd0, pat_active}, 32'd3);
        run_steps(3, 3, 1, 4);

        // Async reset loses a pending load
        load(4);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_led", {24'd0, led_out}, 32'd0);
        chk("mid_rst_pat", {29'd0, pat_active}, 32'd0);
        chk("mid_rst_pulse", {31'd0, step_pulse}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_step(c);
        chk("post_rst_iv", c, 4);
        chk_led("post_rst_frame", 8'h81);
        chk("post_rst_pat", {29'd0, pat_active}, 32'd0);
        run_steps(0, 1, 2, 4);

        // Randomized pattern, speed and pause runs
        for (int it = 0; it < 16; it++) begin
            int sd;
            int p;
            int n;
            int m;
            sd = int'($urandom_range(0, 3));
            p  = int'($urandom_range(0, 7));
            n  = int'($urandom_range(2, 6));
            speed_div = 24'(sd);
            load(p);
            wait_step(c);
            chk_led("rand_first", exp_frame(p, 0));
            chk("rand_pat", {29'd0, pat_active}, p);
            for (int j = 1; j < n; j++) begin
                m = int'($urandom_range(0, 3));
                if (m != 0) begin
                    pause = 1'b1;
                    repeat (m) @(negedge clk);
                    pause = 1'b0;
                end
                wait_step(c);
                chk("rand_iv", c, sd + 1);
                chk_led("rand_frame", exp_frame(p, j));
            end
        end

        // Sparkle: 255 frames per step, all distinct and nonzero
        speed_div = 24'd0;
        load(6);
        seen = '0;
        dups = 0;
        for (int k = 0; k < 255; k++) begin
            wait_step(c);
            chk_led("spark", exp_frame(6, k));
`ifdef LED_PWM_EN
            if (pwm_m < brightness)
`endif
            begin
                if (led_out == 8'h00 || seen[led_out]) dups++;
                seen[led_out] = 1'b1;
            end
        end
        chk("spark_unique", dups, 0);

`ifdef LED_PWM_EN
        speed_div = 24'd3;
        load(3);
        wait_step(c);
        pause = 1'b1;
        brightness = 4'd4;
        c = 0;
        repeat (16) begin
            @(negedge clk);
            if (led_out == 8'hFF) c++;
        end
        chk("pwm_on4", c, 4);
        brightness = 4'd0;
        c = 0;
        repeat (16) begin
            @(negedge clk);
            if (led_out == 8'h00) c++;
        end
        chk("pwm_off", c, 16);
        pause = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
